// File: rtl/rv64_pkg.sv
// rv64_pkg: shared RV64I decode definitions.
//   XLEN / NREG      datapath width and architectural register count
//   reg_idx_t        5-bit register index
//   OPC_*            major opcodes (instr[6:0])
//   imm_fmt_t        immediate format classes
//   imm_fmt_of()     maps a major opcode to its immediate format
package rv64_pkg;

  localparam int XLEN = 64;
  localparam int NREG = 32;

  typedef logic [4:0] reg_idx_t;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_t;

  // Opcodes not listed here (R-type, FENCE, unknown) carry no immediate.
  function automatic imm_fmt_t imm_fmt_of(input logic [6:0] opc);
    imm_fmt_t f;
    case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32,
      OPC_JALR, OPC_SYSTEM:                f = IMM_I;
      OPC_STORE:                           f = IMM_S;
      OPC_BRANCH:                          f = IMM_B;
      OPC_LUI, OPC_AUIPC:                  f = IMM_U;
      OPC_JAL:                             f = IMM_J;
      default:                             f = IMM_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// imm_gen: combinational RV64I immediate decoder.
//   instr  in   32    instruction word
//   fmt    out  enum  immediate format class of the opcode
//   imm    out  XLEN  immediate, sign-extended from instr[31]; 0 when fmt is IMM_NONE
module imm_gen
  import rv64_pkg::*;
(
  input  logic [31:0]     instr,
  output imm_fmt_t        fmt,
  output logic [XLEN-1:0] imm
);

  always_comb begin
    fmt = imm_fmt_of(instr[6:0]);
    imm = '0;
    case (fmt)
      IMM_I: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      IMM_S: imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
      IMM_J: imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12],
                    instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: RV64I decode / operand-fetch stage in front of the register file.
//   clk, reset (async, active low)
//   in_valid/in_ready/in_instr/in_pc     fetch side handshake
//   rf_rs1/rf_rs2, rf_rs1_val/rf_rs2_val register-file read port (combinational data)
//   wb_valid/wb_rd/wb_val                writeback commit, used for bypass and scoreboard clear
//   flush                                discard the held output
//   new_instr                            registered pulse one cycle after an accept
//   out_valid/out_ready/out_*            decoded instruction to execute
// A per-register busy scoreboard is set when an instruction leaves toward
// execute and cleared by its writeback; sources/destinations that are busy stall.
module operand_fetch
  import rv64_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rf_rs1,
  output logic [4:0]      rf_rs2,
  input  logic [XLEN-1:0] rf_rs1_val,
  input  logic [XLEN-1:0] rf_rs2_val,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_val,
  input  logic            flush,
  output logic            new_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [XLEN-1:0] out_imm
);

  // ---------------- field decode ----------------
  logic [6:0]      opcode;
  reg_idx_t        rs1;
  reg_idx_t        rs2;
  reg_idx_t        rd;
  imm_fmt_t        fmt;
  logic [XLEN-1:0] imm;
  logic            uses_rs1;
  logic            uses_rs2;
  logic            writes_rd;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign rf_rs1 = rs1;
  assign rf_rs2 = rs2;

  imm_gen u_imm_gen (
    .instr (in_instr),
    .fmt   (fmt),
    .imm   (imm)
  );

  // STORE and BRANCH are exactly the S/B immediate formats.
  assign uses_rs1  = !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
  assign uses_rs2  = (fmt == IMM_S) || (fmt == IMM_B) ||
                     (opcode == OPC_OP) || (opcode == OPC_OP_32);
  assign writes_rd = !((fmt == IMM_S) || (fmt == IMM_B)) && (rd != 5'd0);

  // ---------------- state ----------------
  logic [NREG-1:0] sb_reg;
  logic [NREG-1:0] sb_next;
  logic            out_valid_reg;
  logic            new_instr_reg;
  logic [XLEN-1:0] out_pc_reg;
  logic [31:0]     out_instr_reg;
  reg_idx_t        out_rd_reg;
  logic [XLEN-1:0] out_rs1_val_reg;
  logic [XLEN-1:0] out_rs2_val_reg;
  logic [XLEN-1:0] out_imm_reg;

  logic            hazard;
  logic            accept;
  logic            issue;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] src_ok;

  // An instruction leaving toward execute owns its rd until writeback.
  // A flushed instruction never issues, so it never marks its rd busy.
  assign issue = out_valid_reg && out_ready && !flush;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      if (gi == 0) begin : g_x0
        assign busy[gi]    = 1'b0;
        assign src_ok[gi]  = 1'b1;
        assign sb_next[gi] = 1'b0;
      end else begin : g_xn
        logic held_here;
        logic set_bit;
        logic clr_bit;
        assign held_here = out_valid_reg && (out_rd_reg == reg_idx_t'(gi));
        assign busy[gi]  = sb_reg[gi] || held_here;
        // A source whose only owner is already past us may be read this
        // cycle from the writeback bus; one still sitting in our output
        // register has not produced its value yet.
        assign src_ok[gi] = !busy[gi] ||
                            (wb_valid && (wb_rd == reg_idx_t'(gi)) &&
                             sb_reg[gi] && !held_here);
        assign set_bit = issue && (out_rd_reg == reg_idx_t'(gi));
        assign clr_bit = wb_valid && (wb_rd == reg_idx_t'(gi));
        // Set beats clear: a new writer issuing while the old one retires.
        assign sb_next[gi] = set_bit ? 1'b1 : (clr_bit ? 1'b0 : sb_reg[gi]);
      end
    end
  endgenerate

  assign hazard   = (uses_rs1 && !src_ok[rs1]) ||
                    (uses_rs2 && !src_ok[rs2]) ||
                    (writes_rd && busy[rd]);
  assign in_ready = reset && !hazard && (!out_valid_reg || out_ready || flush);
  assign accept   = in_valid && in_ready;

  // ---------------- operand selection ----------------
  logic [XLEN-1:0] rs1_cap;
  logic [XLEN-1:0] rs2_cap;

  always_comb begin
    rs1_cap = '0;
    rs2_cap = '0;
    if (uses_rs1 && rs1 != 5'd0)
      rs1_cap = (wb_valid && wb_rd == rs1) ? wb_val : rf_rs1_val;
    if (uses_rs2 && rs2 != 5'd0)
      rs2_cap = (wb_valid && wb_rd == rs2) ? wb_val : rf_rs2_val;
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb_reg          <= '0;
      out_valid_reg   <= 1'b0;
      new_instr_reg   <= 1'b0;
      out_pc_reg      <= '0;
      out_instr_reg   <= '0;
      out_rd_reg      <= '0;
      out_rs1_val_reg <= '0;
      out_rs2_val_reg <= '0;
      out_imm_reg     <= '0;
    end else begin
      sb_reg        <= sb_next;
      new_instr_reg <= accept;
      if (accept) begin
        out_valid_reg   <= 1'b1;
        out_pc_reg      <= in_pc;
        out_instr_reg   <= in_instr;
        out_rd_reg      <= writes_rd ? rd : 5'd0;
        out_rs1_val_reg <= rs1_cap;
        out_rs2_val_reg <= rs2_cap;
        out_imm_reg     <= imm;
      end else if (out_ready || flush) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign new_instr   = new_instr_reg;
  assign out_valid   = out_valid_reg;
  assign out_pc      = out_pc_reg;
  assign out_opcode  = out_instr_reg[6:0];
  assign out_funct3  = out_instr_reg[14:12];
  assign out_funct7  = out_instr_reg[31:25];
  assign out_rd      = out_rd_reg;
  assign out_rs1_val = out_rs1_val_reg;
  assign out_rs2_val = out_rs2_val_reg;
  assign out_imm     = out_imm_reg;

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed self-checking bench for operand_fetch.
// The register file is modelled as rf[r] = 0x1000 + r, so a stale read is
// distinguishable from a bypassed writeback value.
module tb_operand_fetch;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic [4:0]  rf_rs1;
  logic [4:0]  rf_rs2;
  logic [63:0] rf_rs1_val;
  logic [63:0] rf_rs2_val;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_val;
  logic        flush;
  logic        new_instr;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [4:0]  out_rd;
  logic [63:0] out_rs1_val;
  logic [63:0] out_rs2_val;
  logic [63:0] out_imm;

  int total = 0;
  int bad   = 0;

  operand_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .rf_rs1      (rf_rs1),
    .rf_rs2      (rf_rs2),
    .rf_rs1_val  (rf_rs1_val),
    .rf_rs2_val  (rf_rs2_val),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_val      (wb_val),
    .flush       (flush),
    .new_instr   (new_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_opcode  (out_opcode),
    .out_funct3  (out_funct3),
    .out_funct7  (out_funct7),
    .out_rd      (out_rd),
    .out_rs1_val (out_rs1_val),
    .out_rs2_val (out_rs2_val),
    .out_imm     (out_imm)
  );

  assign rf_rs1_val = 64'h1000 + {59'd0, rf_rs1};
  assign rf_rs2_val = 64'h1000 + {59'd0, rf_rs2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-22s observed=%h expected=%h", tag, obs, exp);
  endtask

  localparam logic [31:0] I_ADDI_X1_5   = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] I_ADD_X2_X1   = 32'h00108133; // add  x2,x1,x1
  localparam logic [31:0] I_SW_X3_M4_X2 = 32'hFE312E23; // sw   x3,-4(x2)
  localparam logic [31:0] I_ADDI_X4_M1  = 32'hFFF00213; // addi x4,x0,-1
  localparam logic [31:0] I_ADDI_X8_1   = 32'h00100413; // addi x8,x0,1
  localparam logic [31:0] I_ADD_X9_X4   = 32'h000204B3; // add  x9,x4,x0
  localparam logic [31:0] I_LUI_X5      = 32'h123452B7; // lui  x5,0x12345
  localparam logic [31:0] I_ADD_X6_X5   = 32'h00028333; // add  x6,x5,x0
  localparam logic [31:0] I_LUI_X10_NEG = 32'hFFFFF537; // lui  x10,0xFFFFF

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    wb_valid = 1'b0; wb_rd = '0; wb_val = '0; flush = 1'b0; out_ready = 1'b0;

    // ---- reset state ----
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_new_instr", new_instr, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_out_imm", out_imm, 0);
    reset = 1'b1;

    // ---- ADDI x1,x0,5 ----
    in_valid = 1'b1; in_instr = I_ADDI_X1_5; in_pc = 64'h100; out_ready = 1'b1;
    #1;
    chk("addi_in_ready", in_ready, 1);
    chk("addi_rf_rs1", rf_rs1, 0);
    tick();
    chk("addi_out_valid", out_valid, 1);
    chk("addi_out_rd", out_rd, 1);
    chk("addi_out_imm", out_imm, 64'd5);
    chk("addi_out_rs1", out_rs1_val, 0);
    chk("addi_new_instr", new_instr, 1);
    chk("addi_out_pc", out_pc, 64'h100);
    chk("addi_out_opcode", out_opcode, 7'h13);

    // ---- RAW on x1, resolved via writeback bypass ----
    in_instr = I_ADD_X2_X1; in_pc = 64'h104;
    #1;
    chk("raw_stall_held", in_ready, 0);
    tick();
    chk("raw_new_instr_low", new_instr, 0);
    chk("raw_out_drained", out_valid, 0);
    chk("raw_stall_sb", in_ready, 0);
    tick();
    chk("raw_stall_sb2", in_ready, 0);
    wb_valid = 1'b1; wb_rd = 5'd1; wb_val = 64'd5;
    #1;
    chk("raw_bypass_ready", in_ready, 1);
    tick();
    wb_valid = 1'b0; in_valid = 1'b0;
    chk("add_rs1_bypass", out_rs1_val, 64'd5);
    chk("add_rs2_bypass", out_rs2_val, 64'd5);
    chk("add_out_rd", out_rd, 2);
    chk("add_out_imm", out_imm, 0);
    chk("add_out_funct7", out_funct7, 0);
    tick(); // ADD x2 issues, x2 becomes busy

    // ---- SW x3,-4(x2) with x2 bypassed ----
    in_valid = 1'b1; in_instr = I_SW_X3_M4_X2; in_pc = 64'h108;
    wb_valid = 1'b1; wb_rd = 5'd2; wb_val = 64'h200;
    #1;
    chk("sw_in_ready", in_ready, 1);
    tick();
    wb_valid = 1'b0; in_valid = 1'b0;
    chk("sw_out_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("sw_out_rd", out_rd, 0);
    chk("sw_rs1_bypass", out_rs1_val, 64'h200);
    chk("sw_rs2_rf", out_rs2_val, 64'h1003);
    chk("sw_funct3", out_funct3, 3'b010);
    tick(); // SW issues

    // ---- output hold with out_ready low ----
    out_ready = 1'b0; in_valid = 1'b1; in_instr = I_ADDI_X4_M1; in_pc = 64'h10C;
    #1;
    chk("hold_accept_ready", in_ready, 1);
    tick();
    in_instr = I_ADDI_X8_1; in_pc = 64'h110;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_out_valid", out_valid, 1);
      chk("hold_out_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("hold_out_rd", out_rd, 4);
      chk("hold_out_pc", out_pc, 64'h10C);
      chk("hold_in_ready", in_ready, 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); // handshake, x4 busy
    chk("hold_drained", out_valid, 0);
    in_valid = 1'b1; in_instr = I_ADD_X9_X4; in_pc = 64'h114;
    #1;
    chk("sb4_stall", in_ready, 0);
    wb_valid = 1'b1; wb_rd = 5'd4; wb_val = 64'h44;
    #1;
    chk("sb4_bypass_ready", in_ready, 1);
    tick();
    wb_valid = 1'b0; in_valid = 1'b0;
    chk("x9_rs1_bypass", out_rs1_val, 64'h44);
    tick(); // ADD x9 issues

    // ---- flush of held LUI x5 ----
    out_ready = 1'b0; in_valid = 1'b1; in_instr = I_LUI_X5; in_pc = 64'h120;
    tick();
    chk("lui_out_imm", out_imm, 64'h0000_0000_1234_5000);
    chk("lui_out_rd", out_rd, 5);
    chk("lui_out_rs1", out_rs1_val, 0);
    in_instr = I_ADD_X6_X5; in_pc = 64'h124; flush = 1'b1;
    #1;
    chk("flush_cycle_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    #1;
    chk("after_flush_ready", in_ready, 1);
    tick();
    chk("add6_out_valid", out_valid, 1);
    chk("add6_out_rd", out_rd, 6);
    chk("add6_rs1_rf", out_rs1_val, 64'h1005);

    // ---- async reset while stalled with x1 busy ----
    out_ready = 1'b1; in_instr = I_ADDI_X1_5; in_pc = 64'h128;
    tick(); // ADD x6 issues, ADDI x1 accepted back-to-back
    chk("b2b_out_rd", out_rd, 1);
    in_instr = I_LUI_X10_NEG; in_pc = 64'h12C;
    tick(); // ADDI x1 issues (x1 busy), LUI x10 accepted
    chk("lui_neg_imm", out_imm, 64'hFFFF_FFFF_FFFF_F000);
    in_instr = I_ADD_X2_X1; in_pc = 64'h130;
    #1;
    chk("midstall_ready", in_ready, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_out_imm", out_imm, 0);
    chk("async_out_rd", out_rd, 0);
    chk("async_out_pc", out_pc, 0);
    chk("async_new_instr", new_instr, 0);
    chk("async_in_ready", in_ready, 0);
    tick();
    reset = 1'b1;
    #1;
    chk("post_reset_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("post_reset_rd", out_rd, 2);
    chk("post_reset_rs1", out_rs1_val, 64'h1001);
    chk("post_reset_new", new_instr, 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
